// File: rtl/nn_pkg.sv
// Shared constants and types for the handwritten-digit network datapath.
package nn_pkg;

  localparam int DATA_W     = 32;
  localparam int IMG_PIXELS = 784;

  localparam logic [DATA_W-1:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } acc_state_t;

endpackage

// File: rtl/cla_adder32.sv
// 32-bit carry look-ahead adder: 4-bit lookahead groups, carries chained between groups.
module cla_adder32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        c_i,
  output logic [31:0] sum_o
);

  logic [31:0] g;
  logic [31:0] p;
  logic [31:0] c;

  assign g    = a_i & b_i;
  assign p    = a_i ^ b_i;
  assign c[0] = c_i;

  for (genvar gi = 0; gi < 8; gi++) begin : g_grp
    logic [3:0] gg;
    logic [3:0] pp;
    logic       cin;

    assign gg  = g[4*gi +: 4];
    assign pp  = p[4*gi +: 4];
    assign cin = c[4*gi];

    assign c[4*gi+1] = gg[0] | (pp[0] & cin);
    assign c[4*gi+2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cin);
    assign c[4*gi+3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                     | (pp[2] & pp[1] & pp[0] & cin);

    // The top group's carry-out is not needed: overflow is judged from sign bits.
    if (gi < 7) begin : g_cout
      assign c[4*gi+4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                       | (pp[3] & pp[2] & pp[1] & gg[0])
                       | (pp[3] & pp[2] & pp[1] & pp[0] & cin);
    end
  end

  assign sum_o = p ^ c;

endmodule

// File: rtl/sat_add32.sv
// Combinational signed 32-bit saturating adder built on the CLA adder.
module sat_add32
  import nn_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] raw_sum;

  cla_adder32 u_cla (
    .a_i   (a_i),
    .b_i   (b_i),
    .c_i   (1'b0),
    .sum_o (raw_sum)
  );

  // Like-signed operands producing an opposite-signed result means the true sum left range.
  assign ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) && (raw_sum[DATA_W-1] != a_i[DATA_W-1]);
  assign sum_o = ovf_o ? (a_i[DATA_W-1] ? SAT_MIN : SAT_MAX) : raw_sum;

endmodule

// File: rtl/neuron_accumulator.sv
// Sequential saturating dot-product accumulator for one neuron.
// Build option: define NEURON_ACC_RELU_EN to apply ReLU to out_data.
module neuron_accumulator
  import nn_pkg::*;
#(
  parameter int N_INPUTS = IMG_PIXELS,
  parameter int CNT_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

  acc_state_t        state_q;
  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] acc_d;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              ovf_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;

  sat_add32 u_sat_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (acc_d),
    .ovf_o (ovf_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= ACCUM;
            acc_q      <= bias;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        ACCUM: begin
          if (in_valid && in_ready_q) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + 1'b1;
            ovf_q <= ovf_q | ovf_d;
            if (cnt_q == LAST_CNT) begin
              state_q     <= DONE;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DONE: begin
          // A coincident start is deliberately dropped; the next neuron needs a fresh pulse.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;

`ifdef NEURON_ACC_RELU_EN
  assign out_data = (out_valid_q && !acc_q[DATA_W-1]) ? acc_q : '0;
`else
  assign out_data = out_valid_q ? acc_q : '0;
`endif

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed self-checking bench for neuron_accumulator with N_INPUTS=4.
module tb_neuron_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] bias;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_pass   = 0;

  neuron_accumulator #(.N_INPUTS(4), .CNT_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-14s got=%08h", tag, got);
    end else begin
      $display("FAIL %-14s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1;
    bias  = b;
    tick();
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [31:0] d, input int gap);
    int waited;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) check("beat_timeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic expect_done(input string tag, input logic [31:0] exp);
    int waited = 0;
    while (!out_valid && waited < 50) begin
      tick();
      waited++;
    end
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_low", {31'd0, out_valid}, 32'd0);
    check("hs_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_overflow", {31'd0, overflow}, 32'd0);
    rst = 1'b0;
    tick();

    // bias 10 + 1+2+3+4 with in_valid held high
    do_start(32'd10);
    check("t1_busy", {31'd0, busy}, 32'd1);
    check("t1_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = 32'(i);
      tick();
    end
    in_data = 32'd5;
    check("t1_latency", {31'd0, out_valid}, 32'd1);
    check("t1_no_ready", {31'd0, in_ready}, 32'd0);
    tick();
    in_valid = 1'b0;
    check("t1_data", out_data, 32'd20);
    check("t1_ovf", {31'd0, overflow}, 32'd0);
    handshake();

    // positive saturation, sticky flag
    do_start(32'h7FFF_FFF0);
    send_beat(32'h20, 0);
    send_beat(32'd1, 0);
    send_beat(32'd1, 0);
    send_beat(32'd1, 0);
    in_valid = 1'b0;
    expect_done("t2", 32'h7FFF_FFFF);
    check("t2_ovf_done", {31'd0, overflow}, 32'd1);
    handshake();
    tick();
    check("t2_ovf_idle", {31'd0, overflow}, 32'd1);

    // negative bias; ReLU build clamps to zero
    do_start(-32'sd100);
    check("t3_ovf_clear", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 4; i++) send_beat(32'd5, 0);
    in_valid = 1'b0;
`ifdef NEURON_ACC_RELU_EN
    expect_done("t3", 32'd0);
`else
    expect_done("t3", 32'hFFFF_FFB0);
`endif
    check("t3_ovf", {31'd0, overflow}, 32'd0);
    handshake();

    // negative saturation
    do_start(32'h8000_0010);
    send_beat(32'hFFFF_FFE0, 0);
    send_beat(32'd0, 0);
    send_beat(32'd0, 0);
    send_beat(32'd0, 0);
    in_valid = 1'b0;
`ifdef NEURON_ACC_RELU_EN
    expect_done("t4", 32'd0);
`else
    expect_done("t4", 32'h8000_0000);
`endif
    check("t4_ovf", {31'd0, overflow}, 32'd1);
    handshake();

    // random gaps, ignored starts, output stall: 1000-3+7+100-50 = 1054
    do_start(32'd1000);
    send_beat(-32'sd3, int'($urandom_range(0, 3)));
    in_valid = 1'b0;
    do_start(32'd555);
    check("t5_busy", {31'd0, busy}, 32'd1);
    send_beat(32'd7, int'($urandom_range(0, 3)));
    send_beat(32'd100, int'($urandom_range(0, 3)));
    send_beat(-32'sd50, int'($urandom_range(0, 3)));
    in_valid = 1'b0;
    expect_done("t5", 32'd1054);
    for (int i = 0; i < 5; i++) begin
      start = (i == 2);
      bias  = 32'd9;
      tick();
      check("t5_stall_v", {31'd0, out_valid}, 32'd1);
      check("t5_stall_d", out_data, 32'd1054);
    end
    start = 1'b0;
    handshake();

    // reset mid-operation
    do_start(32'd50);
    send_beat(32'd1, 0);
    send_beat(32'd1, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", {31'd0, busy}, 32'd0);
    check("t6_rst_ready", {31'd0, in_ready}, 32'd0);
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_data", out_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    do_start(32'd0);
    for (int i = 0; i < 4; i++) send_beat(32'd1, 0);
    in_valid = 1'b0;
    expect_done("t6", 32'd4);

    // handshake and start coincide: start dropped, fresh start one cycle later
    out_ready = 1'b1;
    start = 1'b1;
    bias = 32'd99;
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    check("t7_idle", {31'd0, busy}, 32'd0);
    check("t7_valid_low", {31'd0, out_valid}, 32'd0);
    do_start(32'd7);
    check("t7_busy", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) send_beat(32'd0, 0);
    in_valid = 1'b0;
    expect_done("t7", 32'd7);
    handshake();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
